uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit byte stream among NUM_REQUESTERS packet sources.
- Arbitration is round-robin at packet granularity; packets are never interleaved.
- Optionally prefixes each packet with a source-ID header byte.
- Sits between on-chip producers (e.g. debug/trace/response engines) and the uart_controller transmit_data/transmit_valid/transmit_ready interface.

Parameters:
- NUM_REQUESTERS, 4, number of requester ports; legal range 2..16.
- HEADER_ENABLE, 1, 1 = emit header byte before each packet; 0 = payload only.
- HEADER_TAG, 4'hA, upper nibble of the header byte.
- MAX_PACKET_BYTES, 64, payload bytes after which a packet is force-terminated; legal range 1..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8*NUM_REQUESTERS  per-requester byte; requester i occupies [8i+7:8i].
- in_valid  in  NUM_REQUESTERS  per-requester byte valid.
- in_last  in  NUM_REQUESTERS  marks the final byte of a packet; qualified by in_valid.
- in_ready  out  NUM_REQUESTERS  per-requester accept.
- out_data  out  8  to uart_controller transmit_data.
- out_valid  out  1  to transmit_valid.
- out_ready  in  1  from transmit_ready.
- grant  out  NUM_REQUESTERS  one-hot owner of the current packet; 0 when idle.
- busy  out  1  high in HEADER or PAYLOAD.
- overlong  out  1  one-cycle pulse when a packet is force-terminated.

Behaviour:
- Handshake: a byte transfers on any cycle where valid && ready. A producer must hold data, valid and last stable until ready is seen.
- FSM states: IDLE, HEADER, PAYLOAD. Held in registers: state, owner index, last_grant index, byte_count (8 bit).
- Reset values:
  - state=IDLE, last_grant=NUM_REQUESTERS-1 (so requester 0 has first priority), byte_count=0.
  - All outputs 0: out_valid, in_ready, grant, busy, overlong. out_data=0.
- IDLE:
  - out_valid=0, in_ready=0.
  - If any in_valid, pick the first asserted requester scanning last_grant+1, last_grant+2, ... with wrap.
  - Register it as owner. Next state is HEADER if HEADER_ENABLE=1, else PAYLOAD.
  - Arbitration costs one bubble cycle per packet.
- HEADER:
  - out_data={HEADER_TAG, owner[3:0]}, out_valid=1, all in_ready=0.
  - On out_ready, go to PAYLOAD.
  - The header is emitted even if the owner's in_valid has since dropped.
- PAYLOAD:
  - Zero-latency combinational pass-through: out_data=in_data[owner], out_valid=in_valid[owner], in_ready[owner]=out_ready. Every other in_ready=0.
  - Each transfer increments byte_count.
  - End of packet is a transfer with in_last[owner]=1, or the transfer that makes byte_count==MAX_PACKET_BYTES.
  - At end of packet: last_grant<=owner, byte_count<=0, state<=IDLE.
  - If the end was forced and in_last=0, pulse overlong for one cycle. The producer's remaining bytes are arbitrated later as a new packet.
  - If in_last and the limit coincide, the packet terminates normally with no overlong pulse.
- grant: one-hot of owner in HEADER and PAYLOAD, 0 in IDLE. busy = (state != IDLE).
- Owner drops in_valid mid-packet: stay in PAYLOAD with out_valid=0. There is no timeout; other requesters wait.
- Simultaneous requests in IDLE: only the round-robin winner is taken; losers keep in_valid high.
- out_ready low: hold state. out_data stays stable because the producer holds its byte.
- Reset asserted mid-packet: immediately return to the reset values. The partial packet is abandoned and the downstream FIFO keeps any bytes already accepted.

Decomposition:
- Shared package uart_pkg:
  - HEADER_TAG default.
  - State encoding localparams: IDLE=2'd0, HEADER=2'd1, PAYLOAD=2'd2.
  - clog2 helper for the owner index width.
- One natural sub-module: rr_priority_select. It is combinational; inputs are the request vector and last_grant, outputs are the winner index and any_request. It is reusable by the receive-side demux.

Test Plan:
1. Single requester 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), out_ready=1 → out stream 0xA0,0x11,0x22,0x33; grant=4'b0001 for 4 cycles, then 0; no overlong.
2. Requesters 0,1,2 each hold a 2-byte packet at once → header order 0xA0, 0xA1, 0xA2; no interleaving. Then requester 0 requests again while 1 and 3 also request → next winner is 3, then 0, then 1.
3. out_ready toggles 1,0,0,1 during PAYLOAD → each byte appears exactly once; out_data is stable while out_valid && !out_ready.
4. MAX_PACKET_BYTES=4, requester 1 sends 6 bytes with last on byte 6 → first packet 0xA1 + 4 bytes, overlong pulses once; the second packet 0xA1 + 2 bytes terminates normally.
5. HEADER_ENABLE=0, requester 2 sends 0x55 (last) → output is 0x55 only, with one idle bubble cycle before it.
6. Reset asserted after 2 of 5 payload bytes → next cycle busy=0, grant=0, out_valid=0. After release, requester 0 wins first.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter and its
//               round-robin selector: default header tag, arbiter state
//               encoding and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Upper nibble of the per-packet source-ID header byte.
    localparam logic [3:0] c_header_tag = 4'hA;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_t;

    // Index width for n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational round-robin selector. Scans the request vector
//               starting one position after last_grant, wrapping around, and
//               returns the first asserted index.
// Ports       : req         - request vector, one bit per source
//               last_grant  - index granted most recently
//               winner      - selected index (0 when nothing requests)
//               any_request - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner,
    output logic         any_request
);

    logic [W-1:0] w_idx;

    // Walk from the farthest offset to the nearest so the nearest asserted
    // request (highest priority) is the final assignment.
    always_comb begin
        winner      = '0;
        w_idx       = '0;
        any_request = |req;
        for (int k = N; k >= 1; k--) begin
            w_idx = W'((int'(last_grant) + k) % N);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmit byte stream among NUM_REQUESTERS
//               packet sources. Round-robin at packet granularity, optional
//               source-ID header byte, forced termination of overlong packets.
// Ports       : clock, reset            - clock, async active-high reset
//               in_data/in_valid/in_last/in_ready - per-requester byte streams
//               out_data/out_valid/out_ready      - to UART transmitter
//               grant    - one-hot owner of current packet, 0 when idle
//               busy     - a packet is in progress
//               overlong - one-cycle pulse after a forced termination
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQUESTERS   = 4,
    parameter int         HEADER_ENABLE    = 1,
    parameter logic [3:0] HEADER_TAG       = c_header_tag,
    parameter int         MAX_PACKET_BYTES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [8*NUM_REQUESTERS-1:0] in_data,
    input  logic [NUM_REQUESTERS-1:0]   in_valid,
    input  logic [NUM_REQUESTERS-1:0]   in_last,
    output logic [NUM_REQUESTERS-1:0]   in_ready,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_REQUESTERS-1:0]   grant,
    output logic                        busy,
    output logic                        overlong
);

    localparam int c_idx_w = clog2_min1(NUM_REQUESTERS);

    arb_state_t           r_state,      w_state_nx;
    logic [c_idx_w-1:0]   r_owner,      w_owner_nx;
    logic [c_idx_w-1:0]   r_last_grant, w_last_grant_nx;
    logic [7:0]           r_byte_count, w_byte_count_nx;
    logic                 r_overlong,   w_overlong_nx;

    logic [c_idx_w-1:0]        w_winner;
    logic                      w_any;
    logic [7:0]                w_sel_data;
    logic                      w_sel_valid;
    logic                      w_sel_last;
    logic                      w_xfer;
    logic [7:0]                w_count_inc;
    logic                      w_forced;
    logic [NUM_REQUESTERS-1:0] w_owner_onehot;

    rr_priority_select #(
        .N (NUM_REQUESTERS),
        .W (c_idx_w)
    ) u_rr_select (
        .req         (in_valid),
        .last_grant  (r_last_grant),
        .winner      (w_winner),
        .any_request (w_any)
    );

    // Owner's stream, selected for the zero-latency payload pass-through.
    always_comb begin
        w_sel_data  = 8'd0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (r_owner == c_idx_w'(i)) begin
                w_sel_data  = in_data[8*i +: 8];
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
            end
        end
    end

    assign w_xfer         = w_sel_valid && out_ready;
    assign w_count_inc    = r_byte_count + 8'd1;
    assign w_forced       = (w_count_inc == 8'(MAX_PACKET_BYTES));
    assign w_owner_onehot = NUM_REQUESTERS'(1) << r_owner;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_grant <= c_idx_w'(NUM_REQUESTERS - 1);
            r_byte_count <= 8'd0;
            r_overlong   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_owner      <= w_owner_nx;
            r_last_grant <= w_last_grant_nx;
            r_byte_count <= w_byte_count_nx;
            r_overlong   <= w_overlong_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_owner_nx      = r_owner;
        w_last_grant_nx = r_last_grant;
        w_byte_count_nx = r_byte_count;
        w_overlong_nx   = 1'b0;
        out_data        = 8'd0;
        out_valid       = 1'b0;
        in_ready        = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nx = w_winner;
                    w_state_nx = (HEADER_ENABLE != 0) ? HEADER : PAYLOAD;
                end
            end
            HEADER: begin
                // Emitted regardless of the owner's current in_valid.
                out_data  = {HEADER_TAG, 4'(r_owner)};
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nx = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_data  = w_sel_data;
                out_valid = w_sel_valid;
                in_ready  = w_owner_onehot & {NUM_REQUESTERS{out_ready}};
                if (w_xfer) begin
                    w_byte_count_nx = w_count_inc;
                    if (w_sel_last || w_forced) begin
                        w_last_grant_nx = r_owner;
                        w_byte_count_nx = 8'd0;
                        w_state_nx      = IDLE;
                        // Only a limit hit without in_last counts as overlong.
                        w_overlong_nx   = !w_sel_last;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign grant    = busy ? w_owner_onehot : '0;
    assign overlong = r_overlong;

endmodule
`default_nettype wire
